fetch_mem_arbiter: RTL and testbench
====================================

Name: fetch_mem_arbiter

Overview:
- Shares the single external memory port between instruction fetch (IF) and the data-side MEM stage.
- Sequences each multi-cycle memory transaction.
- Returns fetched words to IF using the 2-bit Valid handshake IF already consumes.
- Handles fetch flush on a redirect (Request_Alt_PC) and guards against a hung memory with a timeout.

Parameters:
- STARVE_LIMIT, 4: consecutive MEM grants allowed while an IF request is waiting; once reached, IF wins the next arbitration.
- TIMEOUT, 255: cycles a granted transaction may wait for Mem_Ready before it is aborted with an error.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  synchronous, active-high reset.
- IF_Req  in  1  IF requests a fetch; held until IF_Valid!=0 or IF_Flush.
- IF_Addr  in  32  fetch address; sampled at grant.
- IF_Flush  in  1  redirect; cancels the in-flight or pending fetch.
- IF_Data  out  32  fetched instruction word.
- IF_Valid  out  2  00 = pending, 01 = IF_Data valid (one cycle), 10 = fetch error (one cycle).
- MEM_Req  in  1  MEM stage requests access; held until MEM_Done.
- MEM_Write  in  1  1 = store, 0 = load; sampled at grant.
- MEM_Addr  in  32  data address; sampled at grant.
- MEM_WData  in  32  store data; sampled at grant.
- MEM_RData  out  32  load data.
- MEM_Done  out  1  one-cycle completion pulse.
- MEM_Err  out  1  qualifies MEM_Done: access timed out.
- Mem_Req  out  1  request to the memory port.
- Mem_Write  out  1  write strobe to memory.
- Mem_Addr  out  32  memory address.
- Mem_WData  out  32  memory write data.
- Mem_RData  in  32  memory read data; valid with Mem_Ready.
- Mem_Ready  in  1  memory completes the current access this cycle.

Behaviour:
- States: IDLE, GRANT_IF, GRANT_MEM, DRAIN.
- Mem_Req = 1 exactly when the state is GRANT_IF, GRANT_MEM or DRAIN.
- Mem_Addr, Mem_Write and Mem_WData come from registers latched at grant.
- Mem_Write is 0 in GRANT_IF and DRAIN.

Reset (RESET=1 at a posedge):
- State goes to IDLE.
- IF_Data, MEM_RData and latched address/data registers go to 0.
- IF_Valid=00, MEM_Done=0, MEM_Err=0.
- Starve counter and timeout counter go to 0.
- Reset mid-transaction abandons it; no response is issued, and Mem_Req is 0 in the cycle after reset.

Arbitration (IDLE only):
- Grant MEM if MEM_Req && (!IF_Req || starve<STARVE_LIMIT).
- Otherwise grant IF if IF_Req && !IF_Flush.
- A MEM grant while IF_Req=1 increments starve, saturating at STARVE_LIMIT.
- An IF grant clears starve.

Latency:
- Request seen in IDLE at edge N; Mem_Req=1 from cycle N+1.
- Mem_Ready=1 at edge M returns the state to IDLE, and the response outputs are valid during cycle M+1, for one cycle only.
- Best-case turnaround is 2 cycles.
- No new grant is made on the same edge as a completion; IDLE always lasts at least 1 cycle.

Response:
- GRANT_IF + Mem_Ready: IF_Data<=Mem_RData, IF_Valid<=01.
- GRANT_MEM + Mem_Ready: MEM_Done<=1; MEM_RData<=Mem_RData on a load, held unchanged on a store.
- IF_Valid and MEM_Done are 0 in every other cycle.

Flush:
- IF_Flush in GRANT_IF without Mem_Ready: go to DRAIN.
  - Mem_Req stays high until Mem_Ready, then the state returns to IDLE.
  - The data is discarded and IF_Valid stays 00.
- IF_Flush on the same edge as Mem_Ready in GRANT_IF: the response is discarded, IF_Valid=00.
- IF_Flush in IDLE blocks an IF grant that cycle only.
- IF_Flush in GRANT_MEM has no effect.

Timeout:
- The counter clears on entering any GRANT or DRAIN state and increments each cycle without Mem_Ready.
- When the count reaches TIMEOUT-1 without Mem_Ready, return to IDLE:
  - GRANT_IF: IF_Valid<=10.
  - GRANT_MEM: MEM_Done<=1 and MEM_Err<=1.
  - DRAIN: silent.
- Mem_Ready on the same edge as the timeout: the completion wins.

Test Plan:
- Lone fetch: IF_Req=1, IF_Addr=BFC00000, Mem_Ready 2 cycles after Mem_Req rises, Mem_RData=3C1D0000 -> Mem_Addr=BFC00000, then IF_Valid=01 with IF_Data=3C1D0000 for exactly one cycle.
- Contention: IF_Req and MEM_Req both held high, memory ready in 1 cycle, STARVE_LIMIT=4 -> grant order MEM,MEM,MEM,MEM,IF,MEM,... with starve cleared after the IF grant.
- Store: MEM_Write=1, MEM_Addr=00001000, MEM_WData=DEADBEEF -> Mem_Write=1 with that address/data; MEM_Done pulses with MEM_Err=0; MEM_RData unchanged.
- Flush in flight: IF_Flush pulse during GRANT_IF, Mem_Ready 3 cycles later -> DRAIN, Mem_Req held through ready, IF_Valid stays 00; the next IF_Req is served normally.
- Timeout: TIMEOUT=8, Mem_Ready never asserted during an IF grant -> Mem_Req drops after 8 cycles, IF_Valid=10 for one cycle, state IDLE.
- Reset mid-transaction: RESET=1 during GRANT_MEM -> next cycle Mem_Req=0, MEM_Done=0, IF_Valid=00; a later Mem_Ready pulse is ignored.

Source files
------------

// File: rtl/fetch_mem_arbiter_if.sv
// Signal bundle between the fetch/data-side clients, the arbiter and the external memory port.
// The master modport is the arbiter's view; the slave modport is the clients' and memory's view.
interface fetch_mem_arbiter_if;
    logic        IF_Req;
    logic [31:0] IF_Addr;
    logic        IF_Flush;
    logic [31:0] IF_Data;
    logic [1:0]  IF_Valid;

    logic        MEM_Req;
    logic        MEM_Write;
    logic [31:0] MEM_Addr;
    logic [31:0] MEM_WData;
    logic [31:0] MEM_RData;
    logic        MEM_Done;
    logic        MEM_Err;

    logic        Mem_Req;
    logic        Mem_Write;
    logic [31:0] Mem_Addr;
    logic [31:0] Mem_WData;
    logic [31:0] Mem_RData;
    logic        Mem_Ready;

    modport master (
        input  IF_Req, IF_Addr, IF_Flush,
        input  MEM_Req, MEM_Write, MEM_Addr, MEM_WData,
        input  Mem_RData, Mem_Ready,
        output IF_Data, IF_Valid,
        output MEM_RData, MEM_Done, MEM_Err,
        output Mem_Req, Mem_Write, Mem_Addr, Mem_WData
    );

    modport slave (
        output IF_Req, IF_Addr, IF_Flush,
        output MEM_Req, MEM_Write, MEM_Addr, MEM_WData,
        output Mem_RData, Mem_Ready,
        input  IF_Data, IF_Valid,
        input  MEM_RData, MEM_Done, MEM_Err,
        input  Mem_Req, Mem_Write, Mem_Addr, Mem_WData
    );
endinterface

// File: rtl/fetch_mem_arbiter.sv
// Shares one external memory port between instruction fetch and the MEM stage, with
// starvation-bounded priority for MEM, fetch flush/drain and a per-access timeout.
module fetch_mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic                CLK,
    input  logic                RESET,
    fetch_mem_arbiter_if.master bus
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, GRANT_IF, GRANT_MEM, DRAIN} state_t;

    state_t        state;
    logic [SW-1:0] starve;
    logic [TW-1:0] tcnt;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic          wr_q;
    logic [31:0]   if_data_q;
    logic [1:0]    if_valid_q;
    logic [31:0]   mem_rdata_q;
    logic          mem_done_q;
    logic          mem_err_q;

    logic grant_mem;
    logic grant_if;
    logic timed_out;

    always_comb begin
        grant_mem = bus.MEM_Req && (!bus.IF_Req || (starve < STARVE_MAX));
        grant_if  = !grant_mem && bus.IF_Req && !bus.IF_Flush;
        timed_out = !bus.Mem_Ready && (tcnt == TO_LAST);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= IDLE;
            starve      <= '0;
            tcnt        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wr_q        <= 1'b0;
            if_data_q   <= '0;
            if_valid_q  <= 2'b00;
            mem_rdata_q <= '0;
            mem_done_q  <= 1'b0;
            mem_err_q   <= 1'b0;
        end else begin
            // Response strobes are single-cycle; only a completing edge raises them.
            if_valid_q <= 2'b00;
            mem_done_q <= 1'b0;
            mem_err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    tcnt <= '0;
                    if (grant_mem) begin
                        state   <= GRANT_MEM;
                        addr_q  <= bus.MEM_Addr;
                        wdata_q <= bus.MEM_WData;
                        wr_q    <= bus.MEM_Write;
                        if (bus.IF_Req && (starve != STARVE_MAX)) begin
                            starve <= starve + 1'b1;
                        end
                    end else if (grant_if) begin
                        state  <= GRANT_IF;
                        addr_q <= bus.IF_Addr;
                        wr_q   <= 1'b0;
                        starve <= '0;
                    end
                end
                GRANT_IF: begin
                    if (bus.Mem_Ready) begin
                        state <= IDLE;
                        if (!bus.IF_Flush) begin
                            if_data_q  <= bus.Mem_RData;
                            if_valid_q <= 2'b01;
                        end
                    end else if (bus.IF_Flush) begin
                        // The memory still owes a response; absorb it silently in DRAIN.
                        state <= DRAIN;
                        tcnt  <= '0;
                    end else if (timed_out) begin
                        state      <= IDLE;
                        if_valid_q <= 2'b10;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                GRANT_MEM: begin
                    if (bus.Mem_Ready) begin
                        state      <= IDLE;
                        mem_done_q <= 1'b1;
                        if (!wr_q) begin
                            mem_rdata_q <= bus.Mem_RData;
                        end
                    end else if (timed_out) begin
                        state      <= IDLE;
                        mem_done_q <= 1'b1;
                        mem_err_q  <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (bus.Mem_Ready || timed_out) begin
                        state <= IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.Mem_Req   = (state != IDLE);
    assign bus.Mem_Write = (state == GRANT_MEM) && wr_q;
    assign bus.Mem_Addr  = addr_q;
    assign bus.Mem_WData = wdata_q;
    assign bus.IF_Data   = if_data_q;
    assign bus.IF_Valid  = if_valid_q;
    assign bus.MEM_RData = mem_rdata_q;
    assign bus.MEM_Done  = mem_done_q;
    assign bus.MEM_Err   = mem_err_q;
endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// Bench for fetch_mem_arbiter: directed single-transaction vectors, contention and reset
// sequences, then randomized traffic checked against a transaction-level memory model.
module tb_fetch_mem_arbiter;
    localparam int NEVER = 1000;

    logic CLK = 1'b0;
    logic RESET;

    fetch_mem_arbiter_if bus ();

    fetch_mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(8)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.IF_Req    = 1'b0;
        bus.IF_Addr   = '0;
        bus.IF_Flush  = 1'b0;
        bus.MEM_Req   = 1'b0;
        bus.MEM_Write = 1'b0;
        bus.MEM_Addr  = '0;
        bus.MEM_WData = '0;
        bus.Mem_RData = '0;
        bus.Mem_Ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
    endtask

    typedef struct {
        bit          is_mem;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;       // high cycles before the ready cycle
        int          flush_at;  // high-cycle index to pulse IF_Flush; 0 = with the request; -1 = none
        int          exp_rise;
        int          exp_hi;
        logic [1:0]  exp_ifv;
        logic [31:0] exp_ifdata;
        bit          exp_done;
        bit          exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[11];

    task automatic run_vec(input int n, input vec_t v);
        int hi, rise, fall, ridx, nifv, ndone;
        logic [1:0] gifv;
        logic gerr;
        hi = 0; rise = -1; fall = -1; ridx = -1; nifv = 0; ndone = 0; gifv = 2'b00; gerr = 1'b0;
        bus.IF_Flush = (v.flush_at == 0);
        if (v.is_mem) begin
            bus.MEM_Req   = 1'b1;
            bus.MEM_Write = v.wr;
            bus.MEM_Addr  = v.addr;
            bus.MEM_WData = v.wdata;
        end else begin
            bus.IF_Req  = 1'b1;
            bus.IF_Addr = v.addr;
        end
        for (int i = 1; i <= 24; i++) begin
            @(negedge CLK);
            bus.IF_Flush  = 1'b0;
            bus.Mem_Ready = 1'b0;
            bus.Mem_RData = ~v.rdata;
            if (bus.IF_Valid != 2'b00) begin
                nifv++; gifv = bus.IF_Valid; ridx = i; bus.IF_Req = 1'b0;
            end
            if (bus.MEM_Done) begin
                ndone++; gerr = bus.MEM_Err; ridx = i; bus.MEM_Req = 1'b0;
            end
            if (bus.Mem_Req) begin
                hi++;
                if (rise < 0) begin
                    rise = i;
                    chk($sformatf("vec%0d_mem_addr", n), bus.Mem_Addr, v.addr);
                    chk($sformatf("vec%0d_mem_write", n), 32'(bus.Mem_Write), 32'(v.is_mem && v.wr));
                    if (v.is_mem && v.wr) chk($sformatf("vec%0d_mem_wdata", n), bus.Mem_WData, v.wdata);
                end
                if (hi == v.lat + 1) begin
                    bus.Mem_Ready = 1'b1;
                    bus.Mem_RData = v.rdata;
                end
                if (hi == v.flush_at) begin
                    bus.IF_Flush = 1'b1;
                    bus.IF_Req   = 1'b0;
                end
            end else if (rise >= 0 && fall < 0) begin
                fall = i;
            end
        end
        bus.IF_Req  = 1'b0;
        bus.MEM_Req = 1'b0;
        chk($sformatf("vec%0d_rise", n), rise, v.exp_rise);
        chk($sformatf("vec%0d_req_cycles", n), hi, v.exp_hi);
        chk($sformatf("vec%0d_if_pulses", n), nifv, (v.exp_ifv != 2'b00) ? 1 : 0);
        if (v.exp_ifv != 2'b00) chk($sformatf("vec%0d_if_valid", n), 32'(gifv), 32'(v.exp_ifv));
        chk($sformatf("vec%0d_if_data", n), bus.IF_Data, v.exp_ifdata);
        chk($sformatf("vec%0d_done_pulses", n), ndone, v.exp_done ? 1 : 0);
        if (v.exp_done) chk($sformatf("vec%0d_err", n), 32'(gerr), 32'(v.exp_err));
        chk($sformatf("vec%0d_mem_rdata", n), bus.MEM_RData, v.exp_rdata);
        if (v.exp_done || v.exp_ifv != 2'b00) chk($sformatf("vec%0d_resp_cycle", n), ridx, fall);
    endtask

    // Randomized-phase model: memory contents and the expected starvation count.
    logic [31:0] mem_m [logic [31:0]];

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (mem_m.exists(a)) return mem_m[a];
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    int          starve_m, lat, pred_kind, cur_kind;  // kind: 0 none, 1 IF, 2 MEM
    bit          pred_valid, exp_if_resp, exp_mem_resp, pred_wr, cur_wr, mreq;
    logic [31:0] pred_addr, pred_wdata, cur_addr, cur_wdata, exp_if_data, exp_rdata;

    initial begin
        bit order [12];
        int ng;
        bit was, seen;

        order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
        //           is_mem wr addr          wdata         rdata         lat    fl  rise hi ifv    ifdata        done err rdata
        vecs[0]  = '{0, 0, 32'hBFC0_0000, 32'h0,        32'h3C1D_0000, 2,     -1, 1, 3, 2'b01, 32'h3C1D_0000, 0, 0, 32'h0};
        vecs[1]  = '{1, 0, 32'h0000_2000, 32'h0,        32'h1234_5678, 0,     -1, 1, 1, 2'b00, 32'h3C1D_0000, 1, 0, 32'h1234_5678};
        vecs[2]  = '{1, 1, 32'h0000_1000, 32'hDEAD_BEEF, 32'hFFFF_0000, 1,     -1, 1, 2, 2'b00, 32'h3C1D_0000, 1, 0, 32'h1234_5678};
        vecs[3]  = '{0, 0, 32'h0040_0000, 32'h0,        32'h1111_1111, 3,      1, 1, 4, 2'b00, 32'h3C1D_0000, 0, 0, 32'h1234_5678};
        vecs[4]  = '{0, 0, 32'h0040_0008, 32'h0,        32'h2222_2222, 1,      2, 1, 2, 2'b00, 32'h3C1D_0000, 0, 0, 32'h1234_5678};
        vecs[5]  = '{0, 0, 32'h0040_0004, 32'h0,        32'h27BD_FFF0, 0,     -1, 1, 1, 2'b01, 32'h27BD_FFF0, 0, 0, 32'h1234_5678};
        vecs[6]  = '{0, 0, 32'h0040_0010, 32'h0,        32'h3333_3333, NEVER, -1, 1, 8, 2'b10, 32'h27BD_FFF0, 0, 0, 32'h1234_5678};
        vecs[7]  = '{1, 0, 32'h0000_3000, 32'h0,        32'h4444_4444, NEVER, -1, 1, 8, 2'b00, 32'h27BD_FFF0, 1, 1, 32'h1234_5678};
        vecs[8]  = '{0, 0, 32'h0040_0020, 32'h0,        32'h5555_5555, NEVER,  1, 1, 9, 2'b00, 32'h27BD_FFF0, 0, 0, 32'h1234_5678};
        vecs[9]  = '{1, 0, 32'h0000_4000, 32'h0,        32'h0BAD_F00D, 1,      1, 1, 2, 2'b00, 32'h27BD_FFF0, 1, 0, 32'h0BAD_F00D};
        vecs[10] = '{0, 0, 32'h0040_0040, 32'h0,        32'h8C08_0000, 0,      0, 2, 1, 2'b01, 32'h8C08_0000, 0, 0, 32'h0BAD_F00D};

        // Reset state
        idle_inputs();
        RESET = 1'b1;
        repeat (3) @(negedge CLK);
        chk("rst_mem_req", 32'(bus.Mem_Req), 0);
        chk("rst_mem_write", 32'(bus.Mem_Write), 0);
        chk("rst_mem_addr", bus.Mem_Addr, 0);
        chk("rst_if_valid", 32'(bus.IF_Valid), 0);
        chk("rst_if_data", bus.IF_Data, 0);
        chk("rst_mem_done", 32'(bus.MEM_Done), 0);
        chk("rst_mem_rdata", bus.MEM_RData, 0);
        RESET = 1'b0;
        @(negedge CLK);

        for (int n = 0; n < 11; n++) run_vec(n, vecs[n]);

        // Contention: both sides always requesting, single-cycle memory
        do_reset();
        bus.IF_Addr = 32'h100; bus.MEM_Addr = 32'h200; bus.MEM_Write = 1'b0;
        bus.IF_Req = 1'b1; bus.MEM_Req = 1'b1;
        ng = 0; was = 1'b0;
        for (int i = 0; i < 80 && ng < 12; i++) begin
            @(negedge CLK);
            bus.Mem_Ready = 1'b0;
            if (bus.Mem_Req) begin
                if (!was) begin
                    chk($sformatf("contend_grant%0d", ng), bus.Mem_Addr, order[ng] ? 32'h100 : 32'h200);
                    ng++;
                end
                bus.Mem_Ready = 1'b1;
            end
            was = bus.Mem_Req;
        end
        chk("contend_grant_count", ng, 12);
        idle_inputs();
        repeat (2) @(negedge CLK);

        // Reset in the middle of a MEM access
        bus.MEM_Req = 1'b1; bus.MEM_Write = 1'b0; bus.MEM_Addr = 32'h300;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge CLK);
            seen = bus.Mem_Req;
        end
        chk("rstmid_granted", 32'(seen), 1);
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        bus.MEM_Req = 1'b0;
        chk("rstmid_mem_req", 32'(bus.Mem_Req), 0);
        chk("rstmid_mem_done", 32'(bus.MEM_Done), 0);
        chk("rstmid_if_valid", 32'(bus.IF_Valid), 0);
        chk("rstmid_mem_addr", bus.Mem_Addr, 0);
        bus.Mem_Ready = 1'b1; bus.Mem_RData = 32'hCAFE_F00D;
        @(negedge CLK);
        bus.Mem_Ready = 1'b0;
        chk("rstmid_late_ready_req", 32'(bus.Mem_Req), 0);
        chk("rstmid_late_ready_done", 32'(bus.MEM_Done), 0);
        @(negedge CLK);
        chk("rstmid_late_ready_done2", 32'(bus.MEM_Done), 0);
        chk("rstmid_rdata", bus.MEM_RData, 0);

        // Randomized traffic against the transaction-level model
        do_reset();
        mem_m.delete();
        starve_m = 0; pred_valid = 0; pred_kind = 0; cur_kind = 0; lat = 0;
        exp_if_resp = 0; exp_mem_resp = 0; exp_rdata = '0; exp_if_data = '0;
        cur_addr = '0; cur_wdata = '0; cur_wr = 0; pred_addr = '0; pred_wdata = '0; pred_wr = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge CLK);
            mreq = bus.Mem_Req;
            if (pred_valid) begin
                chk("rnd_grant", 32'(mreq), 32'(pred_kind != 0));
                if (pred_kind != 0 && mreq) begin
                    chk("rnd_addr", bus.Mem_Addr, pred_addr);
                    chk("rnd_write", 32'(bus.Mem_Write), 32'(pred_wr));
                    if (pred_wr) chk("rnd_wdata", bus.Mem_WData, pred_wdata);
                    cur_kind = pred_kind; cur_addr = pred_addr; cur_wr = pred_wr; cur_wdata = pred_wdata;
                    lat = $urandom_range(0, 3);
                end
            end
            pred_valid = 0;

            chk("rnd_if_valid", 32'(bus.IF_Valid), exp_if_resp ? 1 : 0);
            if (exp_if_resp) begin
                chk("rnd_if_data", bus.IF_Data, exp_if_data);
                bus.IF_Req = 1'b0;
            end
            chk("rnd_mem_done", 32'(bus.MEM_Done), 32'(exp_mem_resp));
            if (exp_mem_resp) begin
                chk("rnd_mem_err", 32'(bus.MEM_Err), 0);
                chk("rnd_mem_rdata", bus.MEM_RData, exp_rdata);
                bus.MEM_Req = 1'b0;
            end
            exp_if_resp = 0; exp_mem_resp = 0;

            bus.Mem_Ready = 1'b0;
            bus.Mem_RData = $urandom;
            if (mreq) begin
                if (lat == 0) begin
                    bus.Mem_Ready = 1'b1;
                    if (cur_kind == 1) begin
                        bus.Mem_RData = rd(cur_addr);
                        exp_if_data = bus.Mem_RData;
                        exp_if_resp = 1;
                    end else if (cur_wr) begin
                        mem_m[cur_addr] = cur_wdata;
                        exp_mem_resp = 1;
                    end else begin
                        bus.Mem_RData = rd(cur_addr);
                        exp_rdata = bus.Mem_RData;
                        exp_mem_resp = 1;
                    end
                end else begin
                    lat--;
                end
            end

            if (!bus.IF_Req && $urandom_range(0, 2) == 0) begin
                bus.IF_Req  = 1'b1;
                bus.IF_Addr = 32'h1000 + 32'($urandom_range(0, 7)) * 4;
            end
            if (!bus.MEM_Req && $urandom_range(0, 2) == 0) begin
                bus.MEM_Req   = 1'b1;
                bus.MEM_Write = 1'($urandom_range(0, 1));
                bus.MEM_Addr  = 32'h1000 + 32'($urandom_range(0, 7)) * 4;
                bus.MEM_WData = $urandom;
            end

            if (!mreq) begin
                pred_valid = 1;
                if (bus.MEM_Req && (!bus.IF_Req || starve_m < 4)) begin
                    pred_kind = 2; pred_addr = bus.MEM_Addr; pred_wr = bus.MEM_Write; pred_wdata = bus.MEM_WData;
                    if (bus.IF_Req) starve_m++;
                end else if (bus.IF_Req) begin
                    pred_kind = 1; pred_addr = bus.IF_Addr; pred_wr = 0; pred_wdata = '0;
                    starve_m = 0;
                end else begin
                    pred_kind = 0;
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached with %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end
endmodule
